bp_fe_queue_rollback: RTL
=========================

# bp_fe_queue_rollback

Frontend-side buffer for the FE→BE fetch queue. It accepts fetch packets from the frontend and presents them to the backend checker, which consumes them speculatively with `fe_queue_yumi`. The checker then either commits them with `fe_queue_deq` or rewinds to the last committed entry with `fe_queue_roll`. `clr_i` flushes the whole queue when the frontend takes an `fe_cmd` redirect.

## Interface
Parameters:
- `els_p`, default 8: queue depth. Must be a power of 2 and at least 2.
- `width_p`, default 128: width of one fetch packet (the `fe_queue` width).
- `ptr_width_lp`, derived: `$clog2(els_p)+1`. This includes one wrap bit.

Ports. Clock and reset are one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `fe_queue_i`  in  `width_p`  packet from the frontend.
- `fe_queue_v_i`  in  1  frontend packet valid.
- `fe_queue_ready_o`  out  1  queue can accept a packet. This is a ready→valid handshake.
- `fe_queue_o`  out  `width_p`  packet at the speculative read pointer.
- `fe_queue_v_o`  out  1  an unread packet is available.
- `fe_queue_yumi_i`  in  1  backend consumes `fe_queue_o` this cycle. Legal only when `fe_queue_v_o` is 1.
- `fe_queue_deq_i`  in  1  commit the oldest speculatively read packet.
- `fe_queue_roll_i`  in  1  rewind the read pointer to the commit pointer.
- `clr_i`  in  1  discard all contents.

## Operation
Storage and pointers:
- Storage is a register array of `els_p` × `width_p`.
- There are three `ptr_width_lp` pointers: `wptr`, `rptr` (speculative read) and `cptr` (commit).
- Each array index is the pointer with the MSB dropped. The MSB is the wrap bit.
- The invariant is cptr ≤ rptr ≤ wptr in modular order.

Status:
- Empty: `rptr == wptr`. `fe_queue_v_o = !empty`.
- Full: `wptr - cptr == els_p`, i.e. index bits equal and wrap bits differ. `fe_queue_ready_o = !full` while out of reset.
- Committed entries are freed. Entries that have been read but not committed are not overwritten.

Per-cycle updates:
- **Enqueue.** When `fe_queue_v_i & fe_queue_ready_o & !clr_i`: write `mem[wptr] <= fe_queue_i` and increment `wptr`.
- **Read.** When `fe_queue_yumi_i & !roll_i & !clr_i`: increment `rptr`.
- **Deq.** When `fe_queue_deq_i & (cptr != rptr) & !clr_i`: increment `cptr`. A deq with `cptr == rptr` is ignored and flagged by a simulation assertion.

Simultaneous events:
- **Roll.** `rptr <= cptr_next`, where `cptr_next` already includes a same-cycle deq. Any yumi in the same cycle is ignored. Enqueue still proceeds.
- **Clear.** `wptr`, `rptr` and `cptr` all go to 0 (the reset value). A same-cycle enqueue, yumi, deq or roll is discarded. Array contents are not cleared.
- **Priority order:** clr > roll > yumi; deq is evaluated before roll.
- **Enqueue and yumi in the same cycle when not full:** both proceed.
- **Full:** `fe_queue_ready_o` is 0 until a deq or clr frees an entry. Roll alone does not free entries.

Reset and assertions:
- Asynchronous reset:
  - All pointers go to 0.
  - `fe_queue_v_o = 0` and `fe_queue_ready_o = 0` while `reset_n_i = 0`.
  - `fe_queue_o` is don't-care.
  - Reset mid-operation drops all contents.
- Simulation assertions fire on yumi without valid, and on enqueue while not ready.

## Timing
- Data written in cycle N appears on `fe_queue_o` with `fe_queue_v_o = 1` in cycle N+1. There is no same-cycle bypass.
- `fe_queue_o` and `fe_queue_v_o` are combinational from the array and pointers. They do not depend on `fe_queue_yumi_i`, `fe_queue_deq_i` or `fe_queue_roll_i` in the same cycle.
- `fe_queue_ready_o` depends only on registered pointers, not on `fe_queue_v_i`.
- Roll or clr in cycle N takes effect in cycle N+1:
  - After a roll, `fe_queue_o` shows the oldest uncommitted packet.
  - After a clr, `fe_queue_v_o = 0`.
- Freed capacity after a deq or clr is visible on `fe_queue_ready_o` one cycle later.
- Pointer arithmetic is modulo 2·`els_p` with natural wrap. There is no special case at the wrap point.

## Test plan
- **Reset and fill:** release reset, then enqueue A0..A7 on consecutive cycles (`els_p` = 8) → ready_o = 1 for eight cycles then 0. `v_o` rises one cycle after the A0 write, and `fe_queue_o` = A0.
- **Full until deq:** from full, yumi A0..A3 without deq → ready_o stays 0. Deq once → ready_o = 1 the next cycle, and a new enqueue B0 lands at index 0.
- **Roll:** enqueue A0..A4, yumi A0..A2, deq A0, roll → next cycle `fe_queue_o` = A1. Consuming again yields A1, A2, A3, A4.
- **Simultaneous deq and roll:** with cptr = 1, rptr = 3, assert deq and roll together → cptr = 2, rptr = 2, `fe_queue_o` = A2. A yumi in that cycle is ignored.
- **Clear:** with four entries present, assert clr together with an enqueue of C0 → next cycle `v_o` = 0, ready_o = 1, and C0 is not stored.
- **Wrap-around and async reset:** stream 20 packets with yumi and deq one cycle behind → output order is preserved across pointer wrap. Assert `reset_n_i` low mid-stream → `v_o` and ready_o drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bp_fe_queue_rollback_if.sv
// FE->BE fetch queue handshake bundle: enqueue side, speculative read side and
// the commit/rollback/clear controls driven by the backend checker.
interface bp_fe_queue_rollback_if #(
  parameter int unsigned width_p = 128
) ();
  logic [width_p-1:0] fe_queue_i;
  logic               fe_queue_v_i;
  logic               fe_queue_ready_o;
  logic [width_p-1:0] fe_queue_o;
  logic               fe_queue_v_o;
  logic               fe_queue_yumi_i;
  logic               fe_queue_deq_i;
  logic               fe_queue_roll_i;
  logic               clr_i;

  modport slave (
    input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, fe_queue_deq_i, fe_queue_roll_i, clr_i,
    output fe_queue_ready_o, fe_queue_o, fe_queue_v_o
  );

  modport master (
    output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, fe_queue_deq_i, fe_queue_roll_i, clr_i,
    input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o
  );
endinterface

// File: rtl/bp_fe_queue_rollback.sv
// Fetch queue with speculative read pointer: entries are read with yumi, freed with deq,
// and re-presented from the commit point on roll. clr flushes all pointers.
module bp_fe_queue_rollback #(
  parameter int unsigned els_p   = 8,
  parameter int unsigned width_p = 128
) (
  input logic                      clk_i,
  input logic                      reset_n_i,
  bp_fe_queue_rollback_if.slave    fe_if
);
  localparam int unsigned ptr_width_lp = $clog2(els_p) + 1;
  localparam int unsigned IdxW         = ptr_width_lp - 1;

  typedef logic [ptr_width_lp-1:0] ptr_t;

  logic [width_p-1:0] mem_q [els_p];
  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t cptr_q, cptr_d;

  logic empty, full, enq, deq_ok;

  assign empty = (rptr_q == wptr_q);
  // Full is measured against the commit pointer: read-but-uncommitted entries stay owned.
  assign full  = (wptr_q[IdxW-1:0] == cptr_q[IdxW-1:0]) && (wptr_q[IdxW] != cptr_q[IdxW]);

  assign fe_if.fe_queue_ready_o = reset_n_i & ~full;
  assign fe_if.fe_queue_v_o     = reset_n_i & ~empty;
  assign fe_if.fe_queue_o       = mem_q[rptr_q[IdxW-1:0]];

  assign enq    = fe_if.fe_queue_v_i & fe_if.fe_queue_ready_o & ~fe_if.clr_i;
  assign deq_ok = fe_if.fe_queue_deq_i & (cptr_q != rptr_q) & ~fe_if.clr_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cptr_d = cptr_q;
    if (fe_if.clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cptr_d = '0;
    end else begin
      if (enq)    wptr_d = wptr_q + ptr_t'(1);
      if (deq_ok) cptr_d = cptr_q + ptr_t'(1);
      // Roll lands on the post-deq commit point and overrides any same-cycle yumi.
      if (fe_if.fe_queue_roll_i)     rptr_d = cptr_d;
      else if (fe_if.fe_queue_yumi_i) rptr_d = rptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q[IdxW-1:0]] <= fe_if.fe_queue_i;
  end

  a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fe_if.fe_queue_yumi_i |-> fe_if.fe_queue_v_o);
  a_enq_ready: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fe_if.fe_queue_v_i |-> fe_if.fe_queue_ready_o);
  a_deq_read: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (fe_if.fe_queue_deq_i & ~fe_if.clr_i) |-> (cptr_q != rptr_q));
endmodule
